// File: rtl/pu_ld_obuf_nloop_agen.sv
// OBUF load address generator: walks up to MAX_LOOPS nested loops and splits each word into
// NUM_FIFO sub-beats. Optional stall counter enabled by define PU_LD_OBUF_PERF_CNT_EN.
module pu_ld_obuf_nloop_agen #(
  parameter int unsigned MAX_LOOPS     = 4,
  parameter int unsigned LOOP_ID_W     = $clog2(MAX_LOOPS),
  parameter int unsigned ADDR_WIDTH    = 8,
  parameter int unsigned ADDR_STRIDE_W = ADDR_WIDTH,
  parameter int unsigned LOOP_ITER_W   = 16,
  parameter int unsigned NUM_FIFO      = 2,
  parameter int unsigned FIFO_ID_W     = (NUM_FIFO > 1) ? $clog2(NUM_FIFO) : 0,
  parameter int unsigned MEM_ADDR_W    = ADDR_WIDTH + FIFO_ID_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  output logic                     done,
  output logic                     busy,
  input  logic [ADDR_WIDTH-1:0]    base_addr,
  input  logic                     cfg_loop_iter_v,
  input  logic [LOOP_ITER_W-1:0]   cfg_loop_iter,
  input  logic                     cfg_loop_stride_v,
  input  logic [ADDR_STRIDE_W-1:0] cfg_loop_stride,
  output logic                     mem_req,
  input  logic                     mem_ready,
  output logic [MEM_ADDR_W-1:0]    mem_addr,
  input  logic                     obuf_ld_stream_write_ready
`ifdef PU_LD_OBUF_PERF_CNT_EN
  ,
  output logic [31:0]              stall_cycles
`endif
);

  localparam int unsigned FidW = (FIFO_ID_W > 0) ? FIFO_ID_W : 1;
  localparam int unsigned CntW = LOOP_ID_W + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                   state_q, state_d;
  logic [LOOP_ITER_W-1:0]   iter_q [MAX_LOOPS];
  logic [LOOP_ITER_W-1:0]   iter_d [MAX_LOOPS];
  logic [ADDR_STRIDE_W-1:0] stride_q [MAX_LOOPS];
  logic [ADDR_STRIDE_W-1:0] stride_d [MAX_LOOPS];
  logic [LOOP_ITER_W-1:0]   idx_q [MAX_LOOPS];
  logic [LOOP_ITER_W-1:0]   idx_d [MAX_LOOPS];
  logic [ADDR_WIDTH-1:0]    cur_q [MAX_LOOPS];
  logic [ADDR_WIDTH-1:0]    cur_d [MAX_LOOPS];
  logic [CntW-1:0]          iter_cnt_q, iter_cnt_d, stride_cnt_q, stride_cnt_d;
  logic [CntW-1:0]          nloops_q, nloops_d;
  logic [ADDR_WIDTH-1:0]    word_q, word_d;
  logic [FidW-1:0]          fid_q, fid_d;
  logic                     done_q, done_d, busy_q, busy_d;
  logic                     xfer, fid_last, carry_found;
  logic [LOOP_ID_W-1:0]     carry_j;
  logic [ADDR_WIDTH-1:0]    stride_j, step_addr;

  assign mem_req  = (state_q == StRun) & obuf_ld_stream_write_ready;
  assign xfer     = mem_req & mem_ready;
  assign fid_last = (fid_q == FidW'(NUM_FIFO - 1));
  assign done     = done_q;
  assign busy     = busy_q;

  if (NUM_FIFO > 1) begin : g_fid
    assign mem_addr = {word_q, fid_q};
  end else begin : g_nofid
    assign mem_addr = word_q;
  end

  // Innermost active loop that has not reached its trip count takes the carry.
  always_comb begin
    carry_found = 1'b0;
    carry_j     = '0;
    for (int k = 0; k < MAX_LOOPS; k++) begin
      if (k < int'(nloops_q) && idx_q[k] != iter_q[k]) begin
        carry_found = 1'b1;
        carry_j     = LOOP_ID_W'(k);
      end
    end
  end

  // Unwritten stride slots read as zero.
  assign stride_j  = ({1'b0, carry_j} < stride_cnt_q) ?
                     ADDR_WIDTH'($signed(stride_q[carry_j])) : '0;
  assign step_addr = cur_q[carry_j] + stride_j;

  always_comb begin
    state_d      = state_q;
    iter_d       = iter_q;
    stride_d     = stride_q;
    idx_d        = idx_q;
    cur_d        = cur_q;
    iter_cnt_d   = iter_cnt_q;
    stride_cnt_d = stride_cnt_q;
    nloops_d     = nloops_q;
    word_d       = word_q;
    fid_d        = fid_q;
    unique case (state_q)
      StIdle: begin
        if (cfg_loop_iter_v && iter_cnt_q < CntW'(MAX_LOOPS)) begin
          iter_d[iter_cnt_q[LOOP_ID_W-1:0]] = cfg_loop_iter;
          iter_cnt_d = iter_cnt_q + CntW'(1);
        end
        if (cfg_loop_stride_v && stride_cnt_q < CntW'(MAX_LOOPS)) begin
          stride_d[stride_cnt_q[LOOP_ID_W-1:0]] = cfg_loop_stride;
          stride_cnt_d = stride_cnt_q + CntW'(1);
        end
        if (start) begin
          state_d  = StRun;
          nloops_d = iter_cnt_d;
          word_d   = base_addr;
          fid_d    = '0;
          for (int k = 0; k < MAX_LOOPS; k++) begin
            idx_d[k] = '0;
            cur_d[k] = base_addr;
          end
        end
      end
      StRun: begin
        if (xfer) begin
          if (!fid_last) begin
            fid_d = fid_q + FidW'(1);
          end else begin
            fid_d = '0;
            if (!carry_found) begin
              state_d = StDone;
            end else begin
              word_d = step_addr;
              for (int k = 0; k < MAX_LOOPS; k++) begin
                if (k == int'(carry_j)) begin
                  idx_d[k] = idx_q[k] + LOOP_ITER_W'(1);
                  cur_d[k] = step_addr;
                end else if (k > int'(carry_j)) begin
                  idx_d[k] = '0;
                  cur_d[k] = step_addr;
                end
              end
            end
          end
        end
      end
      StDone: begin
        state_d      = StIdle;
        iter_cnt_d   = '0;
        stride_cnt_d = '0;
      end
      default: state_d = StIdle;
    endcase
    done_d = (state_d == StDone);
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      iter_cnt_q   <= '0;
      stride_cnt_q <= '0;
      nloops_q     <= '0;
      word_q       <= '0;
      fid_q        <= '0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      for (int k = 0; k < MAX_LOOPS; k++) begin
        iter_q[k]   <= '0;
        stride_q[k] <= '0;
        idx_q[k]    <= '0;
        cur_q[k]    <= '0;
      end
    end else begin
      state_q      <= state_d;
      iter_q       <= iter_d;
      stride_q     <= stride_d;
      idx_q        <= idx_d;
      cur_q        <= cur_d;
      iter_cnt_q   <= iter_cnt_d;
      stride_cnt_q <= stride_cnt_d;
      nloops_q     <= nloops_d;
      word_q       <= word_d;
      fid_q        <= fid_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

`ifdef PU_LD_OBUF_PERF_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == StIdle && start) begin
      stall_d = '0;
    end else if (state_q == StRun && !xfer && stall_q != '1) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_pu_ld_obuf_nloop_agen.sv
// Directed bench for pu_ld_obuf_nloop_agen (MAX_LOOPS=4, ADDR_WIDTH=8, NUM_FIFO=2).
module tb_pu_ld_obuf_nloop_agen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        done;
  logic        busy;
  logic [7:0]  base_addr;
  logic        cfg_loop_iter_v;
  logic [15:0] cfg_loop_iter;
  logic        cfg_loop_stride_v;
  logic [7:0]  cfg_loop_stride;
  logic        mem_req;
  logic        mem_ready;
  logic [8:0]  mem_addr;
  logic        wr_ready;
`ifdef PU_LD_OBUF_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  logic [8:0] cap_q[$];
  logic [8:0] exp_q[$];
  int         dones, done_c, last_x, unstable;

  always #5 clk = ~clk;

  pu_ld_obuf_nloop_agen u_dut (
    .clk                        (clk),
    .reset_n                    (reset_n),
    .start                      (start),
    .done                       (done),
    .busy                       (busy),
    .base_addr                  (base_addr),
    .cfg_loop_iter_v            (cfg_loop_iter_v),
    .cfg_loop_iter              (cfg_loop_iter),
    .cfg_loop_stride_v          (cfg_loop_stride_v),
    .cfg_loop_stride            (cfg_loop_stride),
    .mem_req                    (mem_req),
    .mem_ready                  (mem_ready),
    .mem_addr                   (mem_addr),
    .obuf_ld_stream_write_ready (wr_ready)
`ifdef PU_LD_OBUF_PERF_CNT_EN
    ,
    .stall_cycles               (stall_cycles)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cfg(input logic iv, input logic [15:0] it, input logic sv, input logic [7:0] st);
    @(posedge clk); #1;
    cfg_loop_iter_v   = iv;
    cfg_loop_iter     = it;
    cfg_loop_stride_v = sv;
    cfg_loop_stride   = st;
    @(posedge clk); #1;
    cfg_loop_iter_v   = 1'b0;
    cfg_loop_stride_v = 1'b0;
  endtask

  // mode 0: always ready; 1: mem_ready every other cycle; 2: mem_ready low first 5 cycles;
  // 3: always ready with a stray start mid-run.
  task automatic walk(input int mode, input logic [7:0] base);
    int         cyc;
    logic [8:0] prev;
    logic       pend_stall;
    cap_q.delete();
    dones = 0; done_c = -1; last_x = -1; unstable = 0; pend_stall = 1'b0; prev = '0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = base; mem_ready = 1'b1; wr_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (cyc < 200) begin
      mem_ready = (mode == 1) ? ((cyc % 2) == 0) : (mode == 2) ? (cyc >= 5) : 1'b1;
      start     = (mode == 3 && cyc == 2);
      #1;
      if (cyc == 0) check_eq("busy_run", 32'(busy), 32'd1);
      if (pend_stall && mem_addr !== prev) unstable++;
      if (done) begin
        dones++;
        if (done_c < 0) done_c = cyc;
      end
      if (mem_req && mem_ready) begin
        cap_q.push_back(mem_addr);
        last_x = cyc;
      end
      pend_stall = mem_req && !mem_ready;
      prev       = mem_addr;
      if (done_c >= 0 && cyc >= done_c + 2) break;
      @(posedge clk); #1;
      cyc++;
    end
    start     = 1'b0;
    mem_ready = 1'b1;
    check_eq("done_once", 32'(dones), 32'd1);
    check_eq("done_lat", 32'(done_c), 32'(last_x + 1));
    check_eq("busy_after", 32'(busy), 32'd0);
    check_eq("n_xfer", 32'(cap_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      check_eq($sformatf("addr[%0d]", i), 32'(cap_q[i]), 32'(exp_q[i]));
    end
  endtask

  task automatic exp_case2;
    logic [7:0] w[6];
    w[0] = 8'h20; w[1] = 8'h21; w[2] = 8'h22; w[3] = 8'h28; w[4] = 8'h29; w[5] = 8'h2A;
    exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back({w[i], 1'b0});
      exp_q.push_back({w[i], 1'b1});
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; base_addr = '0; mem_ready = 1'b1; wr_ready = 1'b1;
    cfg_loop_iter_v = 1'b0; cfg_loop_iter = '0; cfg_loop_stride_v = 1'b0; cfg_loop_stride = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_req", 32'(mem_req), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_addr", 32'(mem_addr), 32'd0);
    reset_n = 1'b1;

    // NLOOPS=0: one word, two sub-beats
    exp_q.delete();
    exp_q.push_back(9'h020);
    exp_q.push_back(9'h021);
    walk(0, 8'h10);

    // Two loops: outer iter 1 stride 8, inner iter 2 stride 1
    cfg(1'b1, 16'd1, 1'b1, 8'd8);
    cfg(1'b1, 16'd2, 1'b1, 8'd1);
    exp_case2();
    walk(0, 8'h20);

    // Same walk under mem_ready toggling; address must hold across stalls
    cfg(1'b1, 16'd1, 1'b1, 8'd8);
    cfg(1'b1, 16'd2, 1'b1, 8'd1);
    walk(1, 8'h20);
    check_eq("addr_hold", 32'(unstable), 32'd0);

    // Same walk with mem_ready low for 5 run cycles
    cfg(1'b1, 16'd1, 1'b1, 8'd8);
    cfg(1'b1, 16'd2, 1'b1, 8'd1);
    walk(2, 8'h20);
`ifdef PU_LD_OBUF_PERF_CNT_EN
    check_eq("stall_cnt", stall_cycles, 32'd5);
`endif

    // Negative stride wraps; stray start mid-run must not restart
    cfg(1'b1, 16'd3, 1'b1, 8'hFF);
    exp_q.delete();
    exp_q.push_back(9'h002); exp_q.push_back(9'h003);
    exp_q.push_back(9'h000); exp_q.push_back(9'h001);
    exp_q.push_back(9'h1FE); exp_q.push_back(9'h1FF);
    exp_q.push_back(9'h1FC); exp_q.push_back(9'h1FD);
    walk(3, 8'h01);

    // Reset mid-run: no done pulse, config lost
    cfg(1'b1, 16'd3, 1'b1, 8'd1);
    @(posedge clk); #1;
    start = 1'b1; base_addr = 8'h30;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    check_eq("mid_rst_req", 32'(mem_req), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_addr", 32'(mem_addr), 32'd0);
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      if (done) dones++;
      @(posedge clk); #1;
    end
    check_eq("mid_rst_nodone", 32'(dones), 32'd0);
    exp_q.delete();
    exp_q.push_back(9'h080);
    exp_q.push_back(9'h081);
    walk(0, 8'h40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
